// File: rtl/vga_pixel_gen.sv
// vga_pixel_gen: bouncing-box colour stage with 1-pixel re-timed sync/enable outputs.
// Optional 64-pixel grid overlay under the box when VGA_GRID_OVERLAY_EN is defined.
module vga_pixel_gen #(
    parameter int         H_ACTIVE = 640,
    parameter int         V_ACTIVE = 480,
    parameter int         BOX_SIZE = 32,
    parameter int         STEP     = 2,
    parameter int         INIT_X   = 304,
    parameter int         INIT_Y   = 224,
    parameter logic [7:0] BOX_R    = 8'd255,
    parameter logic [7:0] BOX_G    = 8'd35,
    parameter logic [7:0] BOX_B    = 8'd25,
    parameter logic [7:0] BG_R     = 8'd0,
    parameter logic [7:0] BG_G     = 8'd0,
    parameter logic [7:0] BG_B     = 8'd64
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_pix_en,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic       i_enable,
    input  logic       i_hsync,
    input  logic       i_vsync,
    input  logic       i_freeze,
    output logic [7:0] o_r,
    output logic [7:0] o_g,
    output logic [7:0] o_b,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_enable,
    output logic [7:0] o_frame_cnt
);
    localparam logic [10:0] HA = 11'(H_ACTIVE);
    localparam logic [10:0] VA = 11'(V_ACTIVE);
    localparam logic [10:0] BS = 11'(BOX_SIZE);
    localparam logic [10:0] ST = 11'(STEP);

    logic [9:0]  r_box_x, r_box_y;
    logic        r_left, r_up, r_vsync_q;
    logic        w_tick, w_box, w_grid;
    logic [7:0]  w_r, w_g, w_b;
    logic [10:0] w_nx, w_ny;

    // Returns {new_dir, new_pos}; dir 1 means moving towards 0.
    function automatic logic [10:0] f_step(input logic [9:0] pos, input logic back,
                                           input logic [10:0] lim);
        logic [10:0] p;
        p = {1'b0, pos};
        if (back) return (p <= ST) ? 11'd0 : {1'b1, pos - ST[9:0]};
        return (p + BS + ST >= lim) ? {1'b1, 10'(lim - BS)} : {1'b0, pos + ST[9:0]};
    endfunction

    assign w_box = ({1'b0, i_x} >= {1'b0, r_box_x}) && ({1'b0, i_x} < {1'b0, r_box_x} + BS) &&
                   ({1'b0, i_y} >= {1'b0, r_box_y}) && ({1'b0, i_y} < {1'b0, r_box_y} + BS);
`ifdef VGA_GRID_OVERLAY_EN
    assign w_grid = (i_x[5:0] == 6'd0) || (i_y[5:0] == 6'd0);
`else
    assign w_grid = 1'b0;
`endif
    assign w_tick = r_vsync_q & ~i_vsync;
    assign w_nx   = f_step(r_box_x, r_left, HA);
    assign w_ny   = f_step(r_box_y, r_up, VA);

    always_comb begin
        w_r = !i_enable ? 8'd0 : w_box ? BOX_R : w_grid ? 8'd128 : BG_R;
        w_g = !i_enable ? 8'd0 : w_box ? BOX_G : w_grid ? 8'd128 : BG_G;
        w_b = !i_enable ? 8'd0 : w_box ? BOX_B : w_grid ? 8'd128 : BG_B;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_r         <= 8'd0;
            o_g         <= 8'd0;
            o_b         <= 8'd0;
            o_hsync     <= 1'b1;
            o_vsync     <= 1'b1;
            o_enable    <= 1'b0;
            o_frame_cnt <= 8'd0;
            r_box_x     <= 10'(INIT_X);
            r_box_y     <= 10'(INIT_Y);
            r_left      <= 1'b0;
            r_up        <= 1'b0;
            r_vsync_q   <= 1'b1;
        end else if (i_pix_en) begin
            o_r       <= w_r;
            o_g       <= w_g;
            o_b       <= w_b;
            o_hsync   <= i_hsync;
            o_vsync   <= i_vsync;
            o_enable  <= i_enable;
            r_vsync_q <= i_vsync;
            if (w_tick) o_frame_cnt <= o_frame_cnt + 8'd1;
            if (w_tick && !i_freeze) begin
                {r_left, r_box_x} <= w_nx;
                {r_up, r_box_y}   <= w_ny;
            end
        end
    end
endmodule

// File: tb/tb_vga_pixel_gen.sv
// tb_vga_pixel_gen: randomized and directed checks of vga_pixel_gen against a behavioural model.
// Two instances: default start position and one near the bottom-right corner.
module tb_vga_pixel_gen;
    localparam int H = 640, V = 480, BOX = 32, STEP = 2;
    localparam logic [23:0] C_BOX = 24'hFF2319, C_BG = 24'h000040, C_GRID = 24'h808080;

    logic       clk = 1'b0;
    logic       reset = 1'b1, pix_en = 1'b1, enable = 1'b0, hsync = 1'b1, vsync = 1'b1, freeze = 1'b0;
    logic [9:0] x = '0, y = '0;
    logic [7:0] r0, g0, b0, r1, g1, b1, fc0, fc1;
    logic       hs0, vs0, en0, hs1, vs1, en1;
    logic [23:0] rgb [2];
    logic [7:0]  fco [2];
    logic        hso [2], vso [2], eno [2];

    int tests = 0, fails = 0;
    int ix [2] = '{304, 600};
    int iy [2] = '{224, 440};
    int bx [2], by [2], dx [2], dy [2], fc [2];
    bit vq, e_hs, e_vs, e_en;
    logic [23:0] e_rgb [2];

    always #5 clk = ~clk;

    assign rgb[0] = {r0, g0, b0};
    assign rgb[1] = {r1, g1, b1};
    assign fco[0] = fc0;
    assign fco[1] = fc1;
    assign hso = '{hs0, hs1};
    assign vso = '{vs0, vs1};
    assign eno = '{en0, en1};

    vga_pixel_gen dut0 (
        .i_clk(clk), .i_reset(reset), .i_pix_en(pix_en), .i_x(x), .i_y(y), .i_enable(enable),
        .i_hsync(hsync), .i_vsync(vsync), .i_freeze(freeze), .o_r(r0), .o_g(g0), .o_b(b0),
        .o_hsync(hs0), .o_vsync(vs0), .o_enable(en0), .o_frame_cnt(fc0));

    vga_pixel_gen #(.INIT_X(600), .INIT_Y(440)) dut1 (
        .i_clk(clk), .i_reset(reset), .i_pix_en(pix_en), .i_x(x), .i_y(y), .i_enable(enable),
        .i_hsync(hsync), .i_vsync(vsync), .i_freeze(freeze), .o_r(r1), .o_g(g1), .o_b(b1),
        .o_hsync(hs1), .o_vsync(vs1), .o_enable(en1), .o_frame_cnt(fc1));

    function automatic logic [23:0] colour(int k, int px, int py, bit en);
        if (!en) return 24'h0;
        if (px >= bx[k] && px < bx[k] + BOX && py >= by[k] && py < by[k] + BOX) return C_BOX;
`ifdef VGA_GRID_OVERLAY_EN
        if (px % 64 == 0 || py % 64 == 0) return C_GRID;
`endif
        return C_BG;
    endfunction

    task automatic move(int k);
        if (dx[k] > 0) begin
            if (bx[k] + BOX + STEP >= H) begin bx[k] = H - BOX; dx[k] = -1; end
            else bx[k] += STEP;
        end else begin
            if (bx[k] <= STEP) begin bx[k] = 0; dx[k] = 1; end
            else bx[k] -= STEP;
        end
        if (dy[k] > 0) begin
            if (by[k] + BOX + STEP >= V) begin by[k] = V - BOX; dy[k] = -1; end
            else by[k] += STEP;
        end else begin
            if (by[k] <= STEP) begin by[k] = 0; dy[k] = 1; end
            else by[k] -= STEP;
        end
    endtask

    // One clock edge with the current inputs; the model follows what the edge should do.
    task automatic cyc();
        bit tk;
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                bx[k] = ix[k]; by[k] = iy[k]; dx[k] = 1; dy[k] = 1; fc[k] = 0; e_rgb[k] = '0;
            end
            vq = 1; e_hs = 1; e_vs = 1; e_en = 0;
        end else if (pix_en) begin
            tk = vq && !vsync;
            for (int k = 0; k < 2; k++) begin
                e_rgb[k] = colour(k, int'(x), int'(y), enable);
                if (tk) begin
                    fc[k] = (fc[k] + 1) % 256;
                    if (!freeze) move(k);
                end
            end
            vq = vsync; e_hs = hsync; e_vs = vsync; e_en = enable;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1; pix_en = 1; vsync = 1; hsync = 1; freeze = 0; enable = 0;
        cyc();
        reset = 0;
    endtask

    task automatic tick();
        pix_en = 1; vsync = 0; cyc();
        vsync = 1; cyc();
    endtask

    task automatic set_px(int px, int py);
        x = 10'(px); y = 10'(py); enable = 1; pix_en = 1; cyc();
    endtask

    task automatic test_reset();
        reset = 1; pix_en = 1; cyc();
        pix_en = 0; cyc();
        tests++;
        if (rgb[0] !== 24'h0 || hs0 !== 1'b1 || vs0 !== 1'b1 || en0 !== 1'b0 || fc0 !== 8'd0) begin
            fails++;
            $display("FAIL reset: rgb=%h hs=%b vs=%b en=%b fc=%0d, need 000000 1 1 0 0", rgb[0], hs0, vs0, en0, fc0);
        end
        reset = 0; pix_en = 1;
    endtask

    task automatic test_pixels();
        do_reset();
        set_px(310, 230);
        tests++;
        if (rgb[0] !== C_BOX) begin fails++; $display("FAIL box_pixel: got %h need %h", rgb[0], C_BOX); end
        pix_en = 0; x = 10; y = 10; hsync = 0; cyc();
        tests++;
        if (rgb[0] !== C_BOX || hs0 !== 1'b1) begin
            fails++; $display("FAIL hold: got %h hs=%b need %h hs=1", rgb[0], hs0, C_BOX);
        end
        pix_en = 1; cyc();
        tests++;
        if (rgb[0] !== C_BG || hs0 !== 1'b0) begin
            fails++; $display("FAIL bg_pixel: got %h hs=%b need %h hs=0", rgb[0], hs0, C_BG);
        end
        hsync = 1; cyc();
        tests++;
        if (hs0 !== 1'b1) begin fails++; $display("FAIL hsync_release: got %b need 1", hs0); end
    endtask

    task automatic test_frames();
        do_reset();
        tick();
        pix_en = 0; vsync = 0; cyc();
        tests++;
        if (fc0 !== 8'd1) begin fails++; $display("FAIL no_strobe_tick: fc=%0d need 1", fc0); end
        pix_en = 1; cyc();
        tests++;
        if (fc0 !== 8'd2) begin fails++; $display("FAIL delayed_tick: fc=%0d need 2", fc0); end
        vsync = 1; cyc();
        tick();
        tests++;
        if (fc0 !== 8'd3) begin fails++; $display("FAIL three_frames: fc=%0d need 3", fc0); end
        set_px(310, 230);
        tests++;
        if (rgb[0] !== C_BOX) begin fails++; $display("FAIL moved_tl: got %h need %h", rgb[0], C_BOX); end
        set_px(309, 230);
        tests++;
        if (rgb[0] !== C_BG) begin fails++; $display("FAIL moved_left_out: got %h need %h", rgb[0], C_BG); end
        set_px(341, 261);
        tests++;
        if (rgb[0] !== C_BOX) begin fails++; $display("FAIL moved_br: got %h need %h", rgb[0], C_BOX); end
        set_px(342, 261);
        tests++;
        if (rgb[0] !== C_BG) begin fails++; $display("FAIL moved_right_out: got %h need %h", rgb[0], C_BG); end
    endtask

    task automatic test_bounce();
        int ox [8] = '{-1, 0, BOX - 1, BOX, 0, 0, 0, BOX - 1};
        int oy [8] = '{0, 0, BOX - 1, 0, -1, BOX, BOX - 1, BOX};
        do_reset();
        for (int t = 1; t <= 7; t++) begin
            tick();
            for (int i = 0; i < 8; i++) begin
                set_px(bx[1] + ox[i], by[1] + oy[i]);
                tests++;
                if (rgb[1] !== e_rgb[1]) begin
                    fails++;
                    $display("FAIL bounce t%0d p%0d: got %h need %h", t, i, rgb[1], e_rgb[1]);
                end
            end
            if (t == 4) begin
                set_px(639, 479);
                tests++;
                if (rgb[1] !== C_BOX) begin fails++; $display("FAIL corner: got %h need %h", rgb[1], C_BOX); end
            end
            if (t == 5) begin
                set_px(639, 479);
                tests++;
                if (rgb[1] !== C_BG) begin fails++; $display("FAIL corner_leave: got %h need %h", rgb[1], C_BG); end
            end
        end
    endtask

    task automatic test_freeze();
        int f0;
        f0 = fc[0];
        freeze = 1;
        for (int i = 0; i < 5; i++) tick();
        freeze = 0;
        tests++;
        if (fc0 !== 8'((f0 + 5) % 256)) begin fails++; $display("FAIL freeze_count: fc=%0d need %0d", fc0, (f0 + 5) % 256); end
        for (int k = 0; k < 2; k++) begin
            set_px(bx[k], by[k]);
            tests++;
            if (rgb[k] !== C_BOX) begin fails++; $display("FAIL freeze_pos%0d: got %h need %h", k, rgb[k], C_BOX); end
            set_px(bx[k] + BOX, by[k]);
            tests++;
            if (rgb[k] !== e_rgb[k]) begin fails++; $display("FAIL freeze_edge%0d: got %h need %h", k, rgb[k], e_rgb[k]); end
        end
        while (fc[0] != 255) tick();
        tests++;
        if (fc0 !== 8'd255) begin fails++; $display("FAIL count_255: fc=%0d need 255", fc0); end
        tick();
        tests++;
        if (fc0 !== 8'd0) begin fails++; $display("FAIL count_wrap: fc=%0d need 0", fc0); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            pix_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                x = 10'(bx[i % 2] + $urandom_range(0, BOX + 3) - 2);
                y = 10'(by[i % 2] + $urandom_range(0, BOX + 3) - 2);
            end else begin
                x = 10'($urandom_range(0, 639));
                y = 10'($urandom_range(0, 479));
            end
            enable = ($urandom_range(0, 3) != 0);
            hsync = $urandom_range(0, 1) == 1;
            vsync = ($urandom_range(0, 7) != 0);
            freeze = ($urandom_range(0, 3) == 0);
            cyc();
            for (int k = 0; k < 2; k++) begin
                tests++;
                if ({rgb[k], hso[k], vso[k], eno[k], fco[k]} !== {e_rgb[k], e_hs, e_vs, e_en, 8'(fc[k])}) begin
                    fails++;
                    $display("FAIL random%0d dut%0d: rgb=%h hs=%b vs=%b en=%b fc=%0d need rgb=%h hs=%b vs=%b en=%b fc=%0d",
                             i, k, rgb[k], hso[k], vso[k], eno[k], fco[k], e_rgb[k], e_hs, e_vs, e_en, fc[k]);
                end
            end
        end
        freeze = 0; vsync = 1; cyc();
    endtask

    task automatic test_grid();
        logic [23:0] g_exp;
`ifdef VGA_GRID_OVERLAY_EN
        g_exp = C_GRID;
`else
        g_exp = C_BG;
`endif
        do_reset();
        set_px(64, 100);
        tests++;
        if (rgb[0] !== g_exp) begin fails++; $display("FAIL grid: got %h need %h", rgb[0], g_exp); end
        enable = 0; cyc();
        tests++;
        if (rgb[0] !== 24'h0) begin fails++; $display("FAIL grid_blank: got %h need 000000", rgb[0]); end
    endtask

    task automatic test_reset_mid();
        tick(); tick();
        reset = 1; vsync = 0; cyc();
        reset = 0; vsync = 1;
        tests++;
        if (fc0 !== 8'd0) begin fails++; $display("FAIL reset_tick: fc=%0d need 0", fc0); end
        set_px(304, 224);
        tests++;
        if (rgb[0] !== C_BOX) begin fails++; $display("FAIL reset_pos_in: got %h need %h", rgb[0], C_BOX); end
        set_px(303, 224);
        tests++;
        if (rgb[0] !== C_BG) begin fails++; $display("FAIL reset_pos_out: got %h need %h", rgb[0], C_BG); end
    endtask

    initial begin
        test_reset();
        test_pixels();
        test_frames();
        test_bounce();
        test_freeze();
        test_random();
        test_grid();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
